// File: rtl/haar_stage_evaluator.sv
`default_nettype none
// ============================================================================
// Module   : haar_stage_evaluator
// Brief    : Evaluates one Haar cascade stage: streams classifier parameters
//            from the stage ROM, hands rectangle records to the feature unit,
//            accumulates weak-classifier votes and decides stage pass/fail.
// Revision : 1.0 - initial release
// ============================================================================
module haar_stage_evaluator #(
    parameter int DATA_WIDTH_12            = 12,
    parameter int NUM_CLASSIFIERS_STAGE    = 32,
    parameter int NUM_PARAM_PER_CLASSIFIER = 18,
    parameter int NUM_STAGE_THRESHOLD      = 3,
    parameter int FEATURE_WIDTH            = 16,
    parameter int ACC_WIDTH                = 20
) (
    input  logic                                                clk_fpga,
    input  logic                                                reset_fpga,
    input  logic                                                i_start,
    output logic                                                o_rden,
    input  logic                                                i_data_valid,
    input  logic [DATA_WIDTH_12-1:0]                            i_data,
    output logic                                                o_rect_valid,
    output logic [(NUM_PARAM_PER_CLASSIFIER-3)*DATA_WIDTH_12-1:0] o_rect_params,
    input  logic                                                i_feature_valid,
    input  logic [FEATURE_WIDTH-1:0]                            i_feature_value,
    output logic                                                o_done,
    output logic                                                o_pass,
    output logic [ACC_WIDTH-1:0]                                o_stage_sum,
    output logic                                                o_busy
);

    localparam int c_RECT_WORDS = NUM_PARAM_PER_CLASSIFIER - 3;
    localparam int c_IDX_W      = $clog2(c_RECT_WORDS);
    localparam int c_CNT_W      = $clog2(NUM_PARAM_PER_CLASSIFIER + 1);
    localparam int c_CLS_W      = $clog2(NUM_CLASSIFIERS_STAGE + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_REQ_LEN  = c_CNT_W'(NUM_PARAM_PER_CLASSIFIER);
    localparam logic [c_CNT_W-1:0] c_TRL_LEN  = c_CNT_W'(NUM_STAGE_THRESHOLD);
    localparam logic [c_CNT_W-1:0] c_IDX_THR  = c_CNT_W'(NUM_PARAM_PER_CLASSIFIER - 3);
    localparam logic [c_CNT_W-1:0] c_IDX_LEFT = c_CNT_W'(NUM_PARAM_PER_CLASSIFIER - 2);
    localparam logic [c_CNT_W-1:0] c_IDX_LAST = c_CNT_W'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam logic [c_CNT_W-1:0] c_TRL_LAST = c_CNT_W'(NUM_STAGE_THRESHOLD - 1);
    localparam logic [c_CLS_W-1:0] c_CLS_ONE  = c_CLS_W'(1);
    localparam logic [c_CLS_W-1:0] c_CLS_LAST = c_CLS_W'(NUM_CLASSIFIERS_STAGE - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_REQ    = 3'd1;
    localparam logic [2:0] c_S_WAIT   = 3'd2;
    localparam logic [2:0] c_S_VOTE   = 3'd3;
    localparam logic [2:0] c_S_TRL    = 3'd4;
    localparam logic [2:0] c_S_DECIDE = 3'd5;

    logic [2:0]               r_state;
    logic [2:0]               w_next_state;
    logic                     r_rden_d;
    logic [c_CNT_W-1:0]       r_req_cnt;
    logic [c_CNT_W-1:0]       r_rcv_cnt;
    logic [c_CLS_W-1:0]       r_cls_cnt;
    logic [DATA_WIDTH_12-1:0] r_rect_words [c_RECT_WORDS];
    logic [DATA_WIDTH_12-1:0] r_node_thr;
    logic [DATA_WIDTH_12-1:0] r_left;
    logic [DATA_WIDTH_12-1:0] r_right;
    logic [DATA_WIDTH_12-1:0] r_stage_thr;
    logic [FEATURE_WIDTH-1:0] r_feature;
    logic [ACC_WIDTH-1:0]     r_acc;

    logic                     w_accept;
    logic [FEATURE_WIDTH-1:0] w_node_thr_ext;
    logic [DATA_WIDTH_12-1:0] w_vote;
    logic [ACC_WIDTH-1:0]     w_vote_ext;
    logic [ACC_WIDTH-1:0]     w_stage_thr_ext;
    logic                     w_pass;

    // A word is only taken when it answers a request issued the cycle before.
    assign w_accept        = i_data_valid & r_rden_d;
    assign w_node_thr_ext  = {{(FEATURE_WIDTH-DATA_WIDTH_12){r_node_thr[DATA_WIDTH_12-1]}}, r_node_thr};
    assign w_vote          = ($signed(r_feature) < $signed(w_node_thr_ext)) ? r_left : r_right;
    assign w_vote_ext      = {{(ACC_WIDTH-DATA_WIDTH_12){w_vote[DATA_WIDTH_12-1]}}, w_vote};
    assign w_stage_thr_ext = {{(ACC_WIDTH-DATA_WIDTH_12){r_stage_thr[DATA_WIDTH_12-1]}}, r_stage_thr};
    assign w_pass          = ($signed(r_acc) >= $signed(w_stage_thr_ext));

    assign o_busy       = (r_state != c_S_IDLE);
    assign o_rect_valid = (r_state == c_S_WAIT);
    assign o_rden       = ((r_state == c_S_REQ) && (r_req_cnt < c_REQ_LEN)) ||
                          ((r_state == c_S_TRL) && (r_req_cnt < c_TRL_LEN));

    generate
        for (genvar k = 0; k < c_RECT_WORDS; k++) begin : g_pack
            assign o_rect_params[k*DATA_WIDTH_12 +: DATA_WIDTH_12] = r_rect_words[k];
        end
    endgenerate

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:   if (i_start) w_next_state = c_S_REQ;
            c_S_REQ:    if (w_accept && (r_rcv_cnt == c_IDX_LAST)) w_next_state = c_S_WAIT;
            c_S_WAIT:   if (i_feature_valid) w_next_state = c_S_VOTE;
            c_S_VOTE:   w_next_state = (r_cls_cnt == c_CLS_LAST) ? c_S_TRL : c_S_REQ;
            c_S_TRL:    if (w_accept && (r_rcv_cnt == c_TRL_LAST)) w_next_state = c_S_DECIDE;
            c_S_DECIDE: w_next_state = c_S_IDLE;
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            r_rden_d    <= 1'b0;
            r_req_cnt   <= '0;
            r_rcv_cnt   <= '0;
            r_cls_cnt   <= '0;
            for (int k = 0; k < c_RECT_WORDS; k++) r_rect_words[k] <= '0;
            r_node_thr  <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_stage_thr <= '0;
            r_feature   <= '0;
            r_acc       <= '0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_stage_sum <= '0;
        end else begin
            r_rden_d <= o_rden;
            o_done   <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    r_req_cnt <= '0;
                    r_rcv_cnt <= '0;
                    if (i_start) begin
                        r_acc     <= '0;
                        r_cls_cnt <= '0;
                    end
                end
                c_S_REQ: begin
                    if (o_rden) r_req_cnt <= r_req_cnt + c_CNT_ONE;
                    if (w_accept) begin
                        r_rcv_cnt <= r_rcv_cnt + c_CNT_ONE;
                        if (r_rcv_cnt < c_IDX_THR) r_rect_words[r_rcv_cnt[c_IDX_W-1:0]] <= i_data;
                        else if (r_rcv_cnt == c_IDX_THR) r_node_thr <= i_data;
                        else if (r_rcv_cnt == c_IDX_LEFT) r_left <= i_data;
                        else r_right <= i_data;
                    end
                end
                c_S_WAIT: begin
                    if (i_feature_valid) r_feature <= i_feature_value;
                end
                c_S_VOTE: begin
                    r_acc     <= r_acc + w_vote_ext;
                    r_cls_cnt <= r_cls_cnt + c_CLS_ONE;
                    r_req_cnt <= '0;
                    r_rcv_cnt <= '0;
                end
                c_S_TRL: begin
                    if (o_rden) r_req_cnt <= r_req_cnt + c_CNT_ONE;
                    // Only the first trailer word carries the stage threshold.
                    if (w_accept) begin
                        r_rcv_cnt <= r_rcv_cnt + c_CNT_ONE;
                        if (r_rcv_cnt == '0) r_stage_thr <= i_data;
                    end
                end
                c_S_DECIDE: begin
                    o_done      <= 1'b1;
                    o_pass      <= w_pass;
                    o_stage_sum <= r_acc;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
